wb_regfile: RTL and testbench

- Writeback end of the MEM/WB pipeline interface.
- Consumes the latched writeback controls and data, selects the writeback value, and commits it into a 32-entry architectural register file.
- Serves two combinational read ports to the ID stage.
- Exposes the selected writeback value and destination to the forwarding unit, plus a committed-write counter for debug and performance.

---
 rtl/wb_regfile_pkg.sv | 10 +
 rtl/wb_regfile_if.sv | 30 +++
 rtl/wb_regfile_core.sv | 36 +++
 rtl/wb_regfile.sv | 61 ++++++
 tb/tb_wb_regfile.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths, register-zero index and WB control bundle bit positions
package wb_regfile_pkg;
    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 5;
    localparam int CNT_W_DEF       = 32;
    localparam int REG_ZERO        = 0;
    localparam int WB_REGWRITE_BIT = 0;
    localparam int WB_MEMTOREG_BIT = 1;
    typedef logic [1:0] wb_ctrl_t;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback bus, ID read ports and forwarding outputs
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] MemData_i;
    logic [DATA_W-1:0] RegData_i;
    logic [ADDR_W-1:0] RegAddr_i;
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] WBData_o;
    logic [ADDR_W-1:0] WBAddr_o;
    logic              WBValid_o;
    logic [CNT_W-1:0]  WBCount_o;
    modport master (
        output RegWrite_i, MemtoReg_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
        input  RSdata_o, RTdata_o, WBData_o, WBAddr_o, WBValid_o, WBCount_o
    );
    modport slave (
        input  RegWrite_i, MemtoReg_i, MemData_i, RegData_i, RegAddr_i, RSaddr_i, RTaddr_i,
        output RSdata_o, RTdata_o, WBData_o, WBAddr_o, WBValid_o, WBCount_o
    );
endinterface

// File: rtl/wb_regfile_core.sv
// regfile_core: 2R1W register storage with asynchronous clear; index 0 hardwired to zero
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we_i && waddr_i != ZERO) mem_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    assign rdata_a_o = (raddr_a_i == ZERO) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == ZERO) ? '0 : mem_q[raddr_b_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, commit counter and register file; WB_REGFILE_BYPASS_EN makes reads write-first
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_regfile_if.slave  bus
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    wb_ctrl_t          wb_ctrl;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        wb_ctrl                  = '0;
        wb_ctrl[WB_REGWRITE_BIT] = bus.RegWrite_i;
        wb_ctrl[WB_MEMTOREG_BIT] = bus.MemtoReg_i;
        wb_data  = wb_ctrl[WB_MEMTOREG_BIT] ? bus.MemData_i : bus.RegData_i;
        wb_valid = wb_ctrl[WB_REGWRITE_BIT] && (bus.RegAddr_i != ZERO);
        cnt_d    = wb_valid ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wb_valid),
        .waddr_i   (bus.RegAddr_i),
        .wdata_i   (wb_data),
        .raddr_a_i (bus.RSaddr_i),
        .raddr_b_i (bus.RTaddr_i),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // reset gates the bypass so reads stay zero while rst_i is held
    assign bus.RSdata_o = (wb_valid && !rst_i && bus.RSaddr_i == bus.RegAddr_i) ? wb_data : rd_a;
    assign bus.RTdata_o = (wb_valid && !rst_i && bus.RTaddr_i == bus.RegAddr_i) ? wb_data : rd_b;
`else
    assign bus.RSdata_o = rd_a;
    assign bus.RTdata_o = rd_b;
`endif
    assign bus.WBData_o  = wb_data;
    assign bus.WBAddr_o  = bus.RegAddr_i;
    assign bus.WBValid_o = wb_valid;
    assign bus.WBCount_o = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of commit, reg 0, bypass, async reset and counter wrap
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile_if u_if ();
    wb_regfile_if #(.CNT_W(2)) s_if ();

    wb_regfile u_dut (.clk_i(clk), .rst_i(rst), .bus(u_if));
    wb_regfile #(.CNT_W(2)) u_small (.clk_i(clk), .rst_i(rst), .bus(s_if));

    assign s_if.RegWrite_i = u_if.RegWrite_i;
    assign s_if.MemtoReg_i = u_if.MemtoReg_i;
    assign s_if.MemData_i  = u_if.MemData_i;
    assign s_if.RegData_i  = u_if.RegData_i;
    assign s_if.RegAddr_i  = u_if.RegAddr_i;
    assign s_if.RSaddr_i   = u_if.RSaddr_i;
    assign s_if.RTaddr_i   = u_if.RTaddr_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic mtr, input logic [31:0] md,
                         input logic [31:0] rd, input logic [4:0] a);
        @(negedge clk);
        u_if.RegWrite_i = we;
        u_if.MemtoReg_i = mtr;
        u_if.MemData_i  = md;
        u_if.RegData_i  = rd;
        u_if.RegAddr_i  = a;
        #1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        u_if.RegWrite_i = 1'b0;
        u_if.MemtoReg_i = 1'b0;
        u_if.MemData_i  = '0;
        u_if.RegData_i  = '0;
        u_if.RegAddr_i  = '0;
        u_if.RSaddr_i   = '0;
        u_if.RTaddr_i   = '0;
        #3;
        chk("rst_count", u_if.WBCount_o, 32'd0);
        chk("rst_small_count", 32'(s_if.WBCount_o), 32'd0);
        for (int i = 0; i < 32; i++) begin
            u_if.RSaddr_i = 5'(i);
            u_if.RTaddr_i = 5'(31 - i);
            #1;
            chk($sformatf("rst_rs[%0d]", i), u_if.RSdata_o, 32'd0);
            chk($sformatf("rst_rt[%0d]", 31 - i), u_if.RTdata_o, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        u_if.RSaddr_i = 5'd3;
        u_if.RTaddr_i = 5'd3;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_00A5, 5'd3);
        chk("wr3_wbdata", u_if.WBData_o, 32'h0000_00A5);
        chk("wr3_wbvalid", 32'(u_if.WBValid_o), 32'd1);
        chk("wr3_wbaddr", 32'(u_if.WBAddr_o), 32'd3);
`ifdef WB_REGFILE_BYPASS_EN
        chk("wr3_rs_same", u_if.RSdata_o, 32'h0000_00A5);
`else
        chk("wr3_rs_same", u_if.RSdata_o, 32'h0);
`endif
        edge1();
        chk("wr3_rs", u_if.RSdata_o, 32'h0000_00A5);
        chk("wr3_rt", u_if.RTdata_o, 32'h0000_00A5);
        chk("wr3_count", u_if.WBCount_o, 32'd1);

        u_if.RSaddr_i = 5'd7;
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7);
        chk("wr7_wbdata", u_if.WBData_o, 32'hDEAD_BEEF);
        edge1();
        chk("wr7_rs", u_if.RSdata_o, 32'hDEAD_BEEF);
        chk("wr7_rt3", u_if.RTdata_o, 32'h0000_00A5);
        chk("wr7_count", u_if.WBCount_o, 32'd2);

        u_if.RSaddr_i = 5'd0;
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        chk("wr0_wbvalid", 32'(u_if.WBValid_o), 32'd0);
        chk("wr0_rs_same", u_if.RSdata_o, 32'h0);
        edge1();
        chk("wr0_rs", u_if.RSdata_o, 32'h0);
        chk("wr0_count", u_if.WBCount_o, 32'd2);

        u_if.RSaddr_i = 5'd3;
        drive(1'b0, 1'b1, 32'hCAFE_F00D, 32'hBAD0_BAD0, 5'd3);
        chk("nowe_wbvalid", 32'(u_if.WBValid_o), 32'd0);
        edge1();
        chk("nowe_rs3", u_if.RSdata_o, 32'h0000_00A5);
        chk("nowe_count", u_if.WBCount_o, 32'd2);

        u_if.RSaddr_i = 5'd9;
        u_if.RTaddr_i = 5'd9;
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd9);
`ifdef WB_REGFILE_BYPASS_EN
        chk("wr9_rs_same", u_if.RSdata_o, 32'h1234_5678);
        chk("wr9_rt_same", u_if.RTdata_o, 32'h1234_5678);
`else
        chk("wr9_rs_same", u_if.RSdata_o, 32'h0);
        chk("wr9_rt_same", u_if.RTdata_o, 32'h0);
`endif
        edge1();
        chk("wr9_rs", u_if.RSdata_o, 32'h1234_5678);
        chk("wr9_rt", u_if.RTdata_o, 32'h1234_5678);
        chk("wr9_count", u_if.WBCount_o, 32'd3);
        chk("wr9_small_count", 32'(s_if.WBCount_o), 32'd3);

        u_if.RSaddr_i = 5'd5;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd5);
        edge1();
        chk("wr5_rs", u_if.RSdata_o, 32'h0000_0055);
        chk("wr5_count", u_if.WBCount_o, 32'd4);
        chk("wrap_small_count", 32'(s_if.WBCount_o), 32'd0);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rs5", u_if.RSdata_o, 32'h0);
        chk("arst_rt9", u_if.RTdata_o, 32'h0);
        chk("arst_count", u_if.WBCount_o, 32'd0);
        u_if.RSaddr_i = 5'd9;
        u_if.RegWrite_i = 1'b1;
        u_if.RegAddr_i  = 5'd9;
        u_if.RegData_i  = 32'h0000_0077;
        #1;
        chk("arst_held_rs9", u_if.RSdata_o, 32'h0);
        edge1();
        chk("arst_held_edge_rs9", u_if.RSdata_o, 32'h0);
        chk("arst_held_edge_count", u_if.WBCount_o, 32'd0);
        u_if.RegWrite_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 1'b1, 32'h0000_0099, 32'h0, 5'd9);
        edge1();
        chk("post_rst_rs9", u_if.RSdata_o, 32'h0000_0099);
        chk("post_rst_rt9", u_if.RTdata_o, 32'h0000_0099);
        chk("post_rst_count", u_if.WBCount_o, 32'd1);
        u_if.RSaddr_i = 5'd5;
        #1;
        chk("post_rst_rs5", u_if.RSdata_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
